cache_mem_arbiter: RTL and testbench
====================================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter LINE_WORDS, default 8: 16-bit words per cache line; SHALL be a power of 2, at least 2. Let W = log2(LINE_WORDS).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset is synchronous and active-low.
REQ-004 ic_req  in  1  I-cache line-fill request; held high until ic_done.
REQ-005 ic_addr  in  16  I-cache miss address.
REQ-006 dc_req  in  1  D-cache line-fill request; held high until dc_done.
REQ-007 dc_addr  in  16  D-cache miss address.
REQ-008 wr_req  in  1  D-cache write-through request; held high until wr_done.
REQ-009 wr_addr  in  16  write address.
REQ-010 wr_data  in  16  write data.
REQ-011 mem_data_valid  in  1  memory returning valid read data this cycle.
REQ-012 ic_grant / dc_grant  out  1  owner flag, high for the whole fill.
REQ-013 ic_data_valid / dc_data_valid  out  1  mem_data_valid qualified to the owning cache.
REQ-014 fill_word  out  W  word index of the current return (the return counter).
REQ-015 ic_done / dc_done / wr_done  out  1  single-cycle completion pulses.
REQ-016 mem_enable, mem_wr  out  1  memory strobe and write select.
REQ-017 mem_addr  out  16  memory address.
REQ-018 mem_data_out  out  16  write data; equals wr_data in WRITE, 0 otherwise.

Function
REQ-019 FSM states: IDLE, FILL_I, FILL_D, WRITE, DONE; state SHALL be registered.
REQ-020 IDLE arbitration: wr_req highest; then fills per REQ-038/039. Exactly one transition is taken per cycle.
REQ-021 On leaving IDLE, the winning address SHALL be latched. Later changes on *_addr SHALL be ignored until IDLE.
REQ-022 Grants SHALL be registered and asserted from the first FILL cycle through the DONE cycle.
REQ-023 FILL issue: issue_cnt counts 0..LINE_WORDS-1, one per cycle. mem_enable=1, mem_wr=0, mem_addr={latched[15:W+1], issue_cnt, 1'b0}.
REQ-024 After LINE_WORDS issues, mem_enable SHALL be 0 while the FSM waits for returns.
REQ-025 Returns: ret_cnt SHALL increment on mem_data_valid in FILL only. The owner's *_data_valid equals mem_data_valid, and fill_word equals ret_cnt.
REQ-026 When mem_data_valid arrives with ret_cnt = LINE_WORDS-1, the FSM SHALL enter DONE.
REQ-027 DONE lasts 1 cycle: ic_done or dc_done pulses, grant is still high. Counters clear, then IDLE; grant is low in the next cycle.
REQ-028 Returns may overlap issue; issue and return counters are independent. With a 4-cycle memory, a fill takes LINE_WORDS+5 cycles from request to done.
REQ-029 WRITE lasts 1 cycle: mem_enable=1, mem_wr=1, mem_addr=wr_addr, wr_done=1. The FSM then returns to IDLE.
REQ-030 mem_data_valid in IDLE, WRITE or DONE SHALL be ignored; no counter or output changes.
REQ-031 Requester deassertion mid-fill SHALL be ignored; the line completes.
REQ-032 A request still high in the IDLE cycle after its done pulse SHALL be treated as a new request.
REQ-033 Outputs not listed as active in a state SHALL be 0.

Reset
REQ-034 While rst_n=0 at a clock edge: state=IDLE, issue_cnt=ret_cnt=0, latched address=0, last_fill=I.
REQ-035 Reset values: all outputs 0; mem_addr=0; fill_word=0.
REQ-036 Reset mid-fill SHALL abandon the line. A late mem_data_valid SHALL be ignored per REQ-030.
REQ-037 rst_n has no asynchronous effect.

Configuration
REQ-038 Macro ARB_ROUND_ROBIN_EN defined: with both fill requests pending in IDLE, grant the side not served by the most recent fill. last_fill updates on DONE; its reset value is I, so the first contention goes to D.
REQ-039 Macro undefined: dc_req always beats ic_req. last_fill SHALL be absent.
REQ-040 Write priority and all other behaviour are identical in both builds.

Verification
REQ-041 Reset, then idle 5 cycles with mem_data_valid toggling -> all outputs stay 0 and fill_word=0.
REQ-042 ic_req, ic_addr=0x1234, 4-cycle memory model -> mem_addr 0x1230,0x1232,...,0x123E on consecutive cycles. ic_data_valid x8 with fill_word 0..7, then ic_done, 13 cycles after request.
REQ-043 wr_req and dc_req together, wr_addr=0x00A0, wr_data=0xBEEF -> WRITE first: mem_wr=1, mem_data_out=0xBEEF, wr_done. The dc fill follows.
REQ-044 ic_req and dc_req held high for 3 fills -> ARB_ROUND_ROBIN_EN gives D,I,D; macro undefined gives D,D,D.
REQ-045 rst_n low at the 3rd return of a dc fill -> IDLE next cycle with all outputs 0. The remaining 5 returns are ignored; a new ic fill then completes normally.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Line-fill and write-through arbiter sharing one memory port between I/D caches.
// Optional ARB_ROUND_ROBIN_EN alternates contended fills; default gives D-cache priority.

module cache_mem_arbiter #(
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          ic_req_i,
  input  logic [15:0]                   ic_addr_i,
  input  logic                          dc_req_i,
  input  logic [15:0]                   dc_addr_i,
  input  logic                          wr_req_i,
  input  logic [15:0]                   wr_addr_i,
  input  logic [15:0]                   wr_data_i,
  input  logic                          mem_data_valid_i,
  output logic                          ic_grant_o,
  output logic                          dc_grant_o,
  output logic                          ic_data_valid_o,
  output logic                          dc_data_valid_o,
  output logic [$clog2(LINE_WORDS)-1:0] fill_word_o,
  output logic                          ic_done_o,
  output logic                          dc_done_o,
  output logic                          wr_done_o,
  output logic                          mem_enable_o,
  output logic                          mem_wr_o,
  output logic [15:0]                   mem_addr_o,
  output logic [15:0]                   mem_data_out_o
);

  localparam int W = $clog2(LINE_WORDS);
  localparam logic [W:0]   ISS_ONE  = (W+1)'(1);
  localparam logic [W-1:0] RET_ONE  = W'(1);
  localparam logic [W-1:0] RET_LAST = W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL_I,
    S_FILL_D,
    S_WRITE,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [W:0]     issue_cnt_q, issue_cnt_d;
  logic [W-1:0]   ret_cnt_q, ret_cnt_d;
  logic [15:0]    addr_q, addr_d;
  logic           owner_q, owner_d;
  logic           ic_grant_q, ic_grant_d;
  logic           dc_grant_q, dc_grant_d;
  logic           dc_wins;
  logic           issuing;

`ifdef ARB_ROUND_ROBIN_EN
  // last_fill_q: 0 = I-cache, 1 = D-cache served most recently
  logic last_fill_q, last_fill_d;
  always_comb dc_wins = dc_req_i & (~ic_req_i | ~last_fill_q);
`else
  always_comb dc_wins = dc_req_i;
`endif

  // Top bit of the issue counter marks all line words issued.
  assign issuing = ~issue_cnt_q[W];

  assign ic_grant_o = ic_grant_q;
  assign dc_grant_o = dc_grant_q;

  always_comb begin
    state_d         = state_q;
    issue_cnt_d     = issue_cnt_q;
    ret_cnt_d       = ret_cnt_q;
    addr_d          = addr_q;
    owner_d         = owner_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_fill_d     = last_fill_q;
`endif
    ic_data_valid_o = 1'b0;
    dc_data_valid_o = 1'b0;
    fill_word_o     = '0;
    ic_done_o       = 1'b0;
    dc_done_o       = 1'b0;
    wr_done_o       = 1'b0;
    mem_enable_o    = 1'b0;
    mem_wr_o        = 1'b0;
    mem_addr_o      = '0;
    mem_data_out_o  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (wr_req_i) begin
          state_d = S_WRITE;
          addr_d  = wr_addr_i;
        end else if (dc_wins) begin
          state_d = S_FILL_D;
          addr_d  = dc_addr_i;
          owner_d = 1'b1;
        end else if (ic_req_i) begin
          state_d = S_FILL_I;
          addr_d  = ic_addr_i;
          owner_d = 1'b0;
        end
      end

      S_FILL_I, S_FILL_D: begin
        fill_word_o = ret_cnt_q;
        if (issuing) begin
          mem_enable_o = 1'b1;
          mem_addr_o   = {addr_q[15:W+1],
                          issue_cnt_q[W-1:0],
                          1'b0};
          issue_cnt_d  = issue_cnt_q + ISS_ONE;
        end
        if (mem_data_valid_i) begin
          ic_data_valid_o = ~owner_q;
          dc_data_valid_o = owner_q;
          ret_cnt_d       = ret_cnt_q + RET_ONE;
          if (ret_cnt_q == RET_LAST) begin
            state_d = S_DONE;
          end
        end
      end

      S_WRITE: begin
        mem_enable_o   = 1'b1;
        mem_wr_o       = 1'b1;
        mem_addr_o     = addr_q;
        mem_data_out_o = wr_data_i;
        wr_done_o      = 1'b1;
        state_d        = S_IDLE;
      end

      S_DONE: begin
        ic_done_o   = ~owner_q;
        dc_done_o   = owner_q;
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_fill_d = owner_q;
`endif
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Grants follow the next state so they are flopped alongside it.
    ic_grant_d = (state_d == S_FILL_I) ||
                 ((state_d == S_DONE) && !owner_d);
    dc_grant_d = (state_d == S_FILL_D) ||
                 ((state_d == S_DONE) && owner_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      addr_q      <= '0;
      owner_q     <= 1'b0;
      ic_grant_q  <= 1'b0;
      dc_grant_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_fill_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      addr_q      <= addr_d;
      owner_q     <= owner_d;
      ic_grant_q  <= ic_grant_d;
      dc_grant_q  <= dc_grant_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_fill_q <= last_fill_d;
`endif
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: per-cycle transaction model plus directed scenarios.
// Memory returns read data exactly 4 cycles after each issued read.

module tb_cache_mem_arbiter;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req, dc_req, wr_req, mdv;
  logic [15:0] ic_addr, dc_addr, wr_addr, wr_data;
  logic        ic_grant, dc_grant, ic_dv, dc_dv;
  logic [2:0]  fill_word;
  logic        ic_done, dc_done, wr_done;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_dout;
  logic [42:0] outs;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LINE_WORDS(LW)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .ic_req_i         (ic_req),
    .ic_addr_i        (ic_addr),
    .dc_req_i         (dc_req),
    .dc_addr_i        (dc_addr),
    .wr_req_i         (wr_req),
    .wr_addr_i        (wr_addr),
    .wr_data_i        (wr_data),
    .mem_data_valid_i (mdv),
    .ic_grant_o       (ic_grant),
    .dc_grant_o       (dc_grant),
    .ic_data_valid_o  (ic_dv),
    .dc_data_valid_o  (dc_dv),
    .fill_word_o      (fill_word),
    .ic_done_o        (ic_done),
    .dc_done_o        (dc_done),
    .wr_done_o        (wr_done),
    .mem_enable_o     (mem_en),
    .mem_wr_o         (mem_wr),
    .mem_addr_o       (mem_addr),
    .mem_data_out_o   (mem_dout)
  );

  assign outs = {ic_grant, dc_grant, ic_dv, dc_dv, fill_word,
                 ic_done, dc_done, wr_done, mem_en, mem_wr,
                 mem_addr, mem_dout};

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit tog_en = 0;

  int          mq[$];
  logic [15:0] addr_log[$];
  logic [15:0] wa_log[$];
  logic [15:0] wd_log[$];
  bit          ww_log[$];
  int          icw_log[$];
  int          dcw_log[$];
  int          done_log[$];
  int          done_cyc = 0;

  // Model state: mode 0 idle, 1 fill, 2 write, 3 done; own 1 = D-cache
  int          m_mode = 0;
  bit          m_own = 0;
  bit          m_last = 0;
  int          m_base = 0;
  int          m_iss = 0;
  int          m_ret = 0;
  logic [15:0] m_waddr = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Memory: answers each read 4 cycles later; optional idle toggling.
  always @(posedge clk) begin
    bit r;
    cyc++;
    #2;
    r = 1'b0;
    if (mq.size() > 0 && mq[0] == cyc) begin
      void'(mq.pop_front());
      r = 1'b1;
    end
    mdv = r | (tog_en & cyc[0]);
  end

  always @(negedge clk) begin
    logic [42:0] exp;
    bit          e_fill, e_iss;
    logic [15:0] e_addr;
    if (chk_en) begin
      e_fill = (m_mode == 1);
      e_iss  = e_fill && (m_iss < LW);
      e_addr = e_iss ? 16'(m_base + 2 * m_iss) :
               (m_mode == 2) ? m_waddr : 16'h0;
      exp = {(m_mode == 1 || m_mode == 3) && !m_own,
             (m_mode == 1 || m_mode == 3) && m_own,
             e_fill && !m_own && mdv,
             e_fill && m_own && mdv,
             e_fill ? 3'(m_ret) : 3'd0,
             m_mode == 3 && !m_own,
             m_mode == 3 && m_own,
             m_mode == 2,
             e_iss || m_mode == 2,
             m_mode == 2,
             e_addr,
             (m_mode == 2) ? wr_data : 16'h0};
      check($sformatf("cycle %0d outputs", cyc), 64'(outs), 64'(exp));

      if (mem_en && !mem_wr) begin
        addr_log.push_back(mem_addr);
        mq.push_back(cyc + 4);
      end
      if (ic_dv) icw_log.push_back(int'(fill_word));
      if (dc_dv) dcw_log.push_back(int'(fill_word));
      if (ic_done) begin
        done_log.push_back(0);
        done_cyc = cyc;
      end
      if (dc_done) begin
        done_log.push_back(1);
        done_cyc = cyc;
      end
      if (wr_done) begin
        wa_log.push_back(mem_addr);
        wd_log.push_back(mem_dout);
        ww_log.push_back(mem_wr);
      end
    end

    if (!rst_n) begin
      m_mode = 0;
      m_iss  = 0;
      m_ret  = 0;
      m_last = 0;
      m_base = 0;
    end else begin
      case (m_mode)
        0: begin
          if (wr_req) begin
            m_mode  = 2;
            m_waddr = wr_addr;
          end else if (ic_req || dc_req) begin
            if (ic_req && dc_req) begin
`ifdef ARB_ROUND_ROBIN_EN
              m_own = !m_last;
`else
              m_own = 1'b1;
`endif
            end else begin
              m_own = dc_req;
            end
            m_base = int'(m_own ? dc_addr : ic_addr) & ~(2 * LW - 1);
            m_iss  = 0;
            m_ret  = 0;
            m_mode = 1;
          end
        end
        1: begin
          if (m_iss < LW) m_iss++;
          if (mdv) begin
            m_ret++;
            if (m_ret == LW) m_mode = 3;
          end
        end
        2: m_mode = 0;
        3: begin
          m_last = m_own;
          m_mode = 0;
        end
        default: m_mode = 0;
      endcase
    end
  end

  task automatic clear_logs();
    addr_log.delete();
    wa_log.delete();
    wd_log.delete();
    ww_log.delete();
    icw_log.delete();
    dcw_log.delete();
    done_log.delete();
  endtask

  // which: 0 ic_done, 1 dc_done, 2 wr_done
  task automatic wait_pulse(input int which, input int budget,
                            input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        0: seen = ic_done;
        1: seen = dc_done;
        default: seen = wr_done;
      endcase
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic check_words(input string name, input int q[$]);
    check({name, " count"}, 64'(q.size()), 64'd8);
    for (int i = 0; i < q.size() && i < 8; i++)
      check($sformatf("%s word %0d", name, i), 64'(q[i]), 64'(i));
  endtask

  initial begin
    logic [15:0] exp_a[8];
    int          exp_o[3];
    int          t0, n, d;

    exp_a = '{16'h1230, 16'h1232, 16'h1234, 16'h1236,
              16'h1238, 16'h123A, 16'h123C, 16'h123E};
`ifdef ARB_ROUND_ROBIN_EN
    exp_o = '{1, 0, 1};
`else
    exp_o = '{1, 1, 1};
`endif

    rst_n = 1'b0;
    ic_req = 0; dc_req = 0; wr_req = 0; mdv = 0;
    ic_addr = 0; dc_addr = 0; wr_addr = 0; wr_data = 0;

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset outputs", 64'(outs), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle with spurious returns
    tog_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle outputs", 64'(outs), 64'd0);
    end
    @(posedge clk); #1;
    tog_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single I-cache fill; address change mid-fill must not matter
    clear_logs();
    ic_addr = 16'h1234;
    ic_req = 1'b1;
    t0 = cyc;
    repeat (3) @(posedge clk);
    #1 ic_addr = 16'hFFFF;
    wait_pulse(0, 40, "ic fill done");
    @(posedge clk); #1;
    ic_req = 1'b0;
    check("ic latency", 64'(done_cyc - t0), 64'd13);
    check("ic issue count", 64'(addr_log.size()), 64'd8);
    for (int i = 0; i < addr_log.size() && i < 8; i++)
      check($sformatf("ic addr %0d", i), 64'(addr_log[i]), 64'(exp_a[i]));
    check_words("ic return", icw_log);
    repeat (2) @(posedge clk);
    #1;

    // Write beats a concurrent D-cache fill; dc_req drops mid-fill
    clear_logs();
    wr_addr = 16'h00A0;
    wr_data = 16'hBEEF;
    wr_req = 1'b1;
    dc_addr = 16'h5552;
    dc_req = 1'b1;
    wait_pulse(2, 10, "write done");
    @(posedge clk); #1;
    wr_req = 1'b0;
    repeat (4) @(posedge clk);
    #1 dc_req = 1'b0;
    wait_pulse(1, 40, "dc fill done");
    check("write count", 64'(wa_log.size()), 64'd1);
    if (wa_log.size() > 0) begin
      check("write addr", 64'(wa_log[0]), 64'h00A0);
      check("write data", 64'(wd_log[0]), 64'hBEEF);
      check("write mem_wr", 64'(ww_log[0]), 64'd1);
    end
    if (addr_log.size() > 0)
      check("dc first addr", 64'(addr_log[0]), 64'h5550);
    check_words("dc return", dcw_log);
    @(posedge clk); #1;

    // Contention over three back-to-back fills from reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_logs();
    ic_addr = 16'h2000;
    dc_addr = 16'h3000;
    ic_req = 1'b1;
    dc_req = 1'b1;
    n = 0;
    d = 0;
    while (d < 3 && n < 120) begin
      @(negedge clk);
      n++;
      if (ic_done || dc_done) d++;
    end
    check("contention fills", 64'(d), 64'd3);
    @(posedge clk); #1;
    ic_req = 1'b0;
    dc_req = 1'b0;
    for (int i = 0; i < done_log.size() && i < 3; i++)
      check($sformatf("contention owner %0d", i),
            64'(done_log[i]), 64'(exp_o[i]));
    repeat (2) @(posedge clk);
    #1;

    // Reset during the 3rd return of a D-cache fill
    clear_logs();
    dc_addr = 16'h6000;
    dc_req = 1'b1;
    n = 0;
    d = 0;
    while (d < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (dc_dv) d++;
    end
    check("dc returns before reset", 64'(d), 64'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    dc_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset outputs", 64'(outs), 64'd0);
    n = 0;
    while (mq.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    check("abandoned returns", 64'(dcw_log.size()), 64'd3);
    #1;
    clear_logs();
    ic_addr = 16'h4008;
    ic_req = 1'b1;
    wait_pulse(0, 40, "ic after reset done");
    @(posedge clk); #1;
    ic_req = 1'b0;
    check("ic after reset owner", 64'(done_log.size()), 64'd1);
    if (addr_log.size() > 0)
      check("ic after reset addr", 64'(addr_log[0]), 64'h4000);
    check_words("ic after reset", icw_log);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
